// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-port arbiter slice.
package mips_bus_pkg;

    localparam int          BUS_ADDR_W   = 32;
    localparam int          BUS_DATA_W   = 32;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips_bus_mux.sv
// Combinational steering between the two masters and the slave port, selected
// by the arbiter state; nothing reaches the slave outside a grant.
module mips_bus_mux
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  arb_state_t            state,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  s_read,
    output logic                  s_write,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata
);

    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (state)
            GRANT0: begin
                // A simultaneous read+write is treated as a write.
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
            end
            GRANT1: begin
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the shared memory port (fetch m0, data m1).
// ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed m1 > m0 priority.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  s_read,
    output logic                  s_write,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic                  busy
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       m0_req, m1_req;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m0_req && m1_req)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (m1_req)
                    state_d = GRANT1;
                else if (m0_req)
                    state_d = GRANT0;
`else
                if (m1_req)
                    state_d = GRANT1;
                else if (m0_req)
                    state_d = GRANT0;
`endif
            end
            GRANT0: begin
                // A withdrawn request abandons the grant without counting it.
                if (!m0_req) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1_req) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == GRANT0) || (state_q == GRANT1);
    end

    mips_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .state          (state_q),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-owner model.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Model: which master currently owns the bus (-1 = nobody) and who last completed.
    int mdl_owner = -1;
    int mdl_last  = 1;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mips_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .busy(busy)
    );

    always @(posedge clk) begin
        bit r0, r1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = 1;
        end else if (mdl_owner < 0) begin
            if (r0 && r1)      mdl_owner = RR ? 1 - mdl_last : 1;
            else if (r1)       mdl_owner = 1;
            else if (r0)       mdl_owner = 0;
        end else begin
            if (!(mdl_owner == 0 ? r0 : r1)) begin
                mdl_owner = -1;
            end else if (!s_waitrequest) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end
        end
    end

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({s_read, s_write, busy, m0_waitrequest, m1_waitrequest} !== 5'b00011) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got rd/wr/busy/w0/w1=%b expected 00011", i,
                         {s_read, s_write, busy, m0_waitrequest, m1_waitrequest});
            end
            next_cycle();
        end
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || s_address !== 32'h0) begin
                errors++;
                $display("FAIL reset_release_idle: got busy=%b addr=%h expected 0/0", busy, s_address);
            end
            next_cycle();
        end
    endtask

    task automatic test_m0_read();
        m0_read = 1; m0_address = RESET_VECTOR; m0_byteenable = 4'hF;
        s_waitrequest = 0; s_readdata = 32'h24020005;
        @(negedge clk);
        checks++;
        if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_arb_cycle: got s_read=%b wait=%b busy=%b expected 0/1/0", s_read, m0_waitrequest, busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || s_read !== 1'b1 || s_write !== 1'b0 || s_address !== 32'hBFC00000) begin
            errors++;
            $display("FAIL m0_read_grant: got busy=%b rd=%b wr=%b addr=%h expected 1/1/0/bfc00000", busy, s_read, s_write, s_address);
        end
        checks++;
        if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24020005 || m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin
            errors++;
            $display("FAIL m0_read_return: got w0=%b rd0=%h w1=%b rd1=%h expected 0/24020005/1/0", m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_read !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_back_idle: got busy=%b rd=%b expected 0/0", busy, s_read);
        end
        next_cycle();
    endtask

    task automatic test_tie();
        int w;
        rst = 1; idle_inputs();
        next_cycle();
        rst = 0;
        m0_read = 1; m0_address = 32'h0000_00A0;
        m1_read = 1; m1_address = 32'h0000_00A1;
        s_waitrequest = 0;
        w = RR ? 0 : 1;
        for (int pass = 0; pass < 3; pass++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || s_address !== (w == 0 ? 32'hA0 : 32'hA1) ||
                m0_waitrequest !== (w != 0) || m1_waitrequest !== (w != 1)) begin
                errors++;
                $display("FAIL tie_grant pass %0d: got busy=%b addr=%h w0=%b w1=%b expected owner m%0d", pass, busy, s_address, m0_waitrequest, m1_waitrequest, w);
            end
            next_cycle();
            if (pass == 0) begin
                if (w == 0) m0_read = 0; else m1_read = 0;
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || s_read !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_bubble: got busy=%b rd=%b expected 0/0", busy, s_read);
                end
                w = 1 - w;
            end else if (pass == 1) begin
                m0_read = 1; m1_read = 1;
                w = RR ? 0 : 1;
            end else begin
                idle_inputs();
            end
        end
        next_cycle();
    endtask

    task automatic test_wait_hold();
        m1_write = 1; m1_address = 32'h0000_1000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
        s_waitrequest = 1;
        next_cycle();
        m0_read = 1; m0_address = 32'h0000_0044;
        for (int i = 0; i < 4; i++) begin
            s_waitrequest = (i < 3);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h1000 ||
                s_writedata !== 32'hDEADBEEF || s_byteenable !== 4'b0011) begin
                errors++;
                $display("FAIL hold_slave cycle %0d: got busy=%b wr=%b rd=%b addr=%h wd=%h be=%b", i, busy, s_write, s_read, s_address, s_writedata, s_byteenable);
            end
            checks++;
            if (m1_waitrequest !== (i < 3) || m0_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL hold_wait cycle %0d: got w1=%b w0=%b expected %b/1", i, m1_waitrequest, m0_waitrequest, (i < 3));
            end
            next_cycle();
        end
        m1_write = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_read !== 1'b0) begin
            errors++;
            $display("FAIL hold_bubble: got busy=%b rd=%b expected 0/0", busy, s_read);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        m1_write = 1; m1_address = 32'h0000_2000; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
        s_waitrequest = 1;
        next_cycle();
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++;
        if (s_write !== 1'b1 || m1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_before: got wr=%b w1=%b expected 1/1", s_write, m1_waitrequest);
        end
        next_cycle();
        rst = 0; m1_write = 0; s_waitrequest = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: got busy=%b wr=%b w1=%b expected 0/0/1", busy, s_write, m1_waitrequest);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_rw_drop();
        m0_read = 1; m0_write = 1; m0_address = 32'h0000_0300; s_waitrequest = 1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (s_write !== 1'b1 || s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rw_write_wins: got wr=%b rd=%b w0=%b expected 1/0/1", s_write, s_read, m0_waitrequest);
        end
        m0_read = 0; m0_write = 0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_write !== 1'b0) begin
            errors++;
            $display("FAIL drop_to_idle: got busy=%b wr=%b expected 0/0", busy, s_write);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (m0_read | m0_write) begin
                if ($urandom_range(0, 7) == 0) begin m0_read = 0; m0_write = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                m0_read = $urandom_range(0, 1); m0_write = ~m0_read | ($urandom_range(0, 5) == 0);
                m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
            end
            if (m1_read | m1_write) begin
                if ($urandom_range(0, 7) == 0) begin m1_read = 0; m1_write = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                m1_read = $urandom_range(0, 1); m1_write = ~m1_read | ($urandom_range(0, 5) == 0);
                m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            @(negedge clk);
            begin
                logic        e_busy, e_rd, e_wr, e_w0, e_w1;
                logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
                logic [3:0]  e_be;
                e_busy = (mdl_owner >= 0);
                e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_be = '0;
                if (mdl_owner == 0) begin
                    e_rd = m0_read & ~m0_write; e_wr = m0_write; e_addr = m0_address; e_wd = m0_writedata; e_be = m0_byteenable;
                end else if (mdl_owner == 1) begin
                    e_rd = m1_read & ~m1_write; e_wr = m1_write; e_addr = m1_address; e_wd = m1_writedata; e_be = m1_byteenable;
                end
                e_w0  = !(mdl_owner == 0 && !s_waitrequest);
                e_w1  = !(mdl_owner == 1 && !s_waitrequest);
                e_rd0 = (mdl_owner == 0) ? s_readdata : 32'h0;
                e_rd1 = (mdl_owner == 1) ? s_readdata : 32'h0;
                checks++;
                if ({busy, s_read, s_write, m0_waitrequest, m1_waitrequest} !== {e_busy, e_rd, e_wr, e_w0, e_w1}) begin
                    errors++;
                    $display("FAIL rand_ctrl cycle %0d: got busy/rd/wr/w0/w1=%b expected %b", c,
                             {busy, s_read, s_write, m0_waitrequest, m1_waitrequest}, {e_busy, e_rd, e_wr, e_w0, e_w1});
                end
                checks++;
                if (s_address !== e_addr || s_writedata !== e_wd || s_byteenable !== e_be) begin
                    errors++;
                    $display("FAIL rand_slave cycle %0d: got %h/%h/%h expected %h/%h/%h", c, s_address, s_writedata, s_byteenable, e_addr, e_wd, e_be);
                end
                checks++;
                if (m0_readdata !== e_rd0 || m1_readdata !== e_rd1) begin
                    errors++;
                    $display("FAIL rand_readdata cycle %0d: got %h/%h expected %h/%h", c, m0_readdata, m1_readdata, e_rd0, e_rd1);
                end
            end
            next_cycle();
        end
        rst = 1; idle_inputs();
        next_cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_m0_read();
        test_tie();
        test_wait_hold();
        test_reset_mid();
        test_rw_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
